// File: rtl/uart_pkg.sv
// Purpose: shared UART frame constants, receiver FSM encoding and baud divisor lookup.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;
    localparam int unsigned DIV_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic int unsigned baud_rate(input logic [2:0] sel);
        int unsigned rate;
        case (sel)
            3'b000:  rate = 300;
            3'b001:  rate = 1200;
            3'b010:  rate = 4800;
            3'b011:  rate = 9600;
            3'b100:  rate = 19200;
            3'b101:  rate = 38400;
            3'b110:  rate = 57600;
            default: rate = 115200;
        endcase
        return rate;
    endfunction

    // Rounded clocks per 16x tick: round(clk_hz / (16 * baud)).
    // At 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
    function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clk_hz,
                                                      input logic [2:0]  sel);
        int unsigned tick_hz;
        tick_hz = baud_rate(sel) * OVERSAMPLE;
        return DIV_W'((clk_hz + tick_hz / 2) / tick_hz);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: loadable divisor counter producing a one-clk 16x oversampling tick enable.
// Latency: first tick 'divisor' clks after restart, then one tick every 'divisor' clks.
// Backpressure: none; free-running once loaded.
// Ports: clk, rst (async active-high), restart (sync reload + divisor capture),
//        divisor (clks per tick, sampled only on restart), tick (one-clk enable).
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    // Divisor is captured on restart so the rate stays fixed for a whole frame
    // even if the select input changes underneath it.
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else if (restart) begin
            div_q <= divisor;
            cnt   <= divisor - 1'b1;
        end else if (cnt == '0) begin
            cnt <= div_q - 1'b1;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Purpose: 16x-oversampling UART receiver (8 data bits, even parity, 1 stop) with status strobes.
// Latency: strobes 10.5 bit times + 3 clks (+/-1 tick) after the falling start edge on RxD.
// Backpressure: none; each frame yields one-clk pulses that the consumer must catch.
// Ports: clk, reset (async active-high), baud_select (rate code, latched per frame),
//        Rx_EN (low forces idle), RxD (async serial in), Rx_DATA (last good byte),
//        Rx_VALID / Rx_PERROR / Rx_FERROR (one-clk completion pulses).
module uart_rx_core #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    import uart_pkg::*;

    localparam logic [3:0] MID_TICK_C = 4'(MID_TICK);
    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    logic sync1;
    logic line;
    logic line_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b1;
            line      <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= RxD;
            line      <= sync1;
            line_prev <= line;
        end
    end

    rx_state_t             state;
    rx_state_t             state_n;
    logic [3:0]            tick_cnt;
    logic [2:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  par_q;
    logic                  tick;
    logic                  start_det;
    logic                  mid_hit;
    logic                  bit_hit;
    logic                  perr_c;
    logic                  ferr_c;
    logic [DIV_W-1:0]      divisor;

    // A real 1->0 transition is required, so a held-low line (break) never
    // re-triggers until it has returned high.
    assign start_det = Rx_EN && (state == ST_IDLE) && line_prev && !line;
    assign mid_hit   = tick && (tick_cnt == MID_TICK_C);
    assign bit_hit   = tick && (tick_cnt == LAST_TICK);
    assign perr_c    = par_q ^ (^shift_q);
    assign ferr_c    = !line;

    // Divisor for the live select; the tick generator captures it on the start
    // edge, which is what pins the baud rate for the rest of the frame.
    assign divisor = baud_divisor(CLK_HZ, baud_select);

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (reset),
        .restart (start_det),
        .divisor (divisor),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:   if (start_det) state_n = ST_START;
            ST_START:  if (mid_hit) state_n = line ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_hit && (bit_cnt == LAST_BIT)) state_n = ST_PARITY;
            ST_PARITY: if (bit_hit) state_n = ST_STOP;
            ST_STOP:   if (bit_hit) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
        if (!Rx_EN) begin
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            Rx_DATA   <= 8'h00;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
            if (!Rx_EN) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start_det) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                    ST_START: begin
                        // Restarting the count at the mid-start sample puts every
                        // later sample 16 ticks on, i.e. mid-bit.
                        if (tick) begin
                            tick_cnt <= mid_hit ? 4'd0 : tick_cnt + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                        if (bit_hit) begin
                            shift_q <= {line, shift_q[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (tick) begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                        if (bit_hit) begin
                            par_q <= line;
                        end
                    end
                    ST_STOP: begin
                        if (tick) begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                        if (bit_hit) begin
                            Rx_PERROR <= perr_c;
                            Rx_FERROR <= ferr_c;
                            Rx_VALID  <= !perr_c && !ferr_c;
                            if (!perr_c && !ferr_c) begin
                                Rx_DATA <= shift_q;
                            end
                        end
                    end
                    default: begin
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Purpose: self-checking bench for uart_rx_core using a frame vector table plus corner sequences.
// Latency: checks strobe timing against 168 ticks + 3 clks from the start edge.
// Backpressure: n/a.
module tb_uart_rx_core;

    logic       clk;
    logic       reset;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    uart_rx_core #(
        .CLK_HZ     (50000000),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Rx_EN       (Rx_EN),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR)
    );

    // Clocks per 16x tick at 50 MHz, and clocks per bit.
    localparam int DIV_115200 = 27;
    localparam int DIV_38400  = 81;
    localparam int BIT_FAST   = 16 * DIV_115200;
    localparam int BIT_MID    = 16 * DIV_38400;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled on the falling edge.
    int         v_cnt = 0;
    int         p_cnt = 0;
    int         f_cnt = 0;
    int         v_cyc = 0;
    int         start_cyc = 0;
    logic [7:0] vlog [0:7];

    always @(negedge clk) begin
        if (!reset) begin
            if (Rx_VALID) begin
                if (v_cnt < 8) vlog[v_cnt] = Rx_DATA;
                v_cnt = v_cnt + 1;
                v_cyc = cyc;
            end
            if (Rx_PERROR) p_cnt = p_cnt + 1;
            if (Rx_FERROR) f_cnt = f_cnt + 1;
        end
    end

    task automatic clear_counts();
        v_cnt = 0;
        p_cnt = 0;
        f_cnt = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks = checks + 1;
        if (act < lo || act > hi) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a falling edge; leaves the line idle high afterwards.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int n);
        start_cyc = cyc;
        RxD = 1'b0;
        wait_clks(n);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            wait_clks(n);
        end
        RxD = par;
        wait_clks(n);
        RxD = stp;
        wait_clks(n);
        RxD = 1'b1;
    endtask

    task automatic chk_frame(input string tag, input int ev, input int ep, input int ef,
                             input logic [7:0] ed, input int div);
        chk({tag, "_valid_cnt"},  v_cnt, ev);
        chk({tag, "_perror_cnt"}, p_cnt, ep);
        chk({tag, "_ferror_cnt"}, f_cnt, ef);
        chk({tag, "_data"},       int'(Rx_DATA), int'(ed));
        if (ev == 1) begin
            chk_range({tag, "_latency"}, v_cyc - start_cyc,
                      168 * div + 3 - div, 168 * div + 3 + div);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        int         exp_v;
        int         exp_p;
        int         exp_f;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        // data, parity bit, stop bit -> valid, perror, ferror, Rx_DATA after frame
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};  // good frame
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 0, 1, 0, 8'hA5};  // bad parity, data held
        vecs[2] = '{8'h01, 1'b1, 1'b0, 0, 0, 1, 8'hA5};  // stop low only
        vecs[3] = '{8'h0F, 1'b1, 1'b0, 0, 1, 1, 8'hA5};  // both errors together
        vecs[4] = '{8'hC3, 1'b0, 1'b1, 1, 0, 0, 8'hC3};  // good frame updates data

        reset       = 1'b1;
        RxD         = 1'b1;
        Rx_EN       = 1'b1;
        baud_select = 3'b111;
        wait_clks(4);
        chk("reset_data",   int'(Rx_DATA),   0);
        chk("reset_valid",  int'(Rx_VALID),  0);
        chk("reset_perror", int'(Rx_PERROR), 0);
        chk("reset_ferror", int'(Rx_FERROR), 0);
        reset = 1'b0;
        wait_clks(BIT_FAST);

        for (int i = 0; i < 5; i++) begin
            clear_counts();
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stp, BIT_FAST);
            wait_clks(BIT_FAST);
            chk_frame($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_p, vecs[i].exp_f,
                      vecs[i].exp_data, DIV_115200);
        end

        // False start: 4 ticks low is gone before the mid-start sample.
        clear_counts();
        RxD = 1'b0;
        wait_clks(4 * DIV_115200);
        RxD = 1'b1;
        wait_clks(BIT_FAST);
        chk("glitch_valid_cnt",  v_cnt, 0);
        chk("glitch_perror_cnt", p_cnt, 0);
        chk("glitch_ferror_cnt", f_cnt, 0);
        clear_counts();
        send_frame(8'h5A, 1'b0, 1'b1, BIT_FAST);
        wait_clks(BIT_FAST);
        chk_frame("after_glitch", 1, 0, 0, 8'h5A, DIV_115200);

        // Receiver disabled mid data bit 4 of 0xFF; re-enabled during the stop bit
        // so no falling edge is seen while enabled.
        clear_counts();
        RxD = 1'b0;
        wait_clks(BIT_FAST);
        for (int i = 0; i < 4; i++) begin
            RxD = 1'b1;
            wait_clks(BIT_FAST);
        end
        wait_clks(BIT_FAST / 2);
        Rx_EN = 1'b0;
        wait_clks(BIT_FAST / 2 + 3 * BIT_FAST);
        RxD = 1'b0;                     // parity of 0xFF is 0
        wait_clks(BIT_FAST);
        RxD = 1'b1;                     // stop
        wait_clks(BIT_FAST / 2);
        Rx_EN = 1'b1;
        wait_clks(BIT_FAST / 2 + BIT_FAST);
        chk("abort_valid_cnt",  v_cnt, 0);
        chk("abort_perror_cnt", p_cnt, 0);
        chk("abort_ferror_cnt", f_cnt, 0);
        clear_counts();
        send_frame(8'h81, 1'b0, 1'b1, BIT_FAST);
        wait_clks(BIT_FAST);
        chk_frame("after_abort", 1, 0, 0, 8'h81, DIV_115200);

        // Back-to-back frames with zero idle between them.
        clear_counts();
        send_frame(8'h11, 1'b0, 1'b1, BIT_FAST);
        send_frame(8'h22, 1'b0, 1'b1, BIT_FAST);
        send_frame(8'h33, 1'b0, 1'b1, BIT_FAST);
        wait_clks(BIT_FAST);
        chk("b2b_valid_cnt", v_cnt, 3);
        chk("b2b_data0", int'(vlog[0]), 8'h11);
        chk("b2b_data1", int'(vlog[1]), 8'h22);
        chk("b2b_data2", int'(vlog[2]), 8'h33);
        chk("b2b_errors", p_cnt + f_cnt, 0);

        // Reset in the middle of the parity bit, then a frame at 38400 with the
        // select changed mid-frame (must have no effect).
        baud_select = 3'b101;
        clear_counts();
        RxD = 1'b0;
        wait_clks(BIT_MID);
        for (int i = 0; i < 8; i++) begin
            RxD = i[0];                 // 0x55-ish pattern, LSB first
            wait_clks(BIT_MID);
        end
        RxD = 1'b0;
        wait_clks(BIT_MID / 2);
        chk("pre_reset_data", int'(Rx_DATA), 8'h33);
        #2;
        reset = 1'b1;
        RxD   = 1'b1;
        #1;
        chk("midreset_data",   int'(Rx_DATA),   0);
        chk("midreset_valid",  int'(Rx_VALID),  0);
        chk("midreset_perror", int'(Rx_PERROR), 0);
        chk("midreset_ferror", int'(Rx_FERROR), 0);
        wait_clks(3);
        reset = 1'b0;
        wait_clks(BIT_MID);
        chk("post_reset_pulses", v_cnt + p_cnt + f_cnt, 0);
        clear_counts();
        fork
            send_frame(8'h7E, 1'b0, 1'b1, BIT_MID);
            begin
                wait_clks(2 * BIT_MID);
                baud_select = 3'b000;
            end
        join
        wait_clks(BIT_MID);
        chk_frame("after_reset", 1, 0, 0, 8'h7E, DIV_38400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
